// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared FSM state and mode encodings for the priority arbiter
package arb_pkg;

    // Arbiter FSM: IDLE arbitrates, GRANT holds one winner until it ends
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Arbitration policy selected by the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - combinational downward-searching priority encoder with wrap
module prio_enc_n #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_index
);

    // Candidate order is start, start-1, ..., 0, N-1, ..., start+1.
    // Walking the distance from the far end back to 0 lets the nearest set bit
    // overwrite any farther one, so the last hit is the winner.
    always_comb begin
        int w_idx;
        o_found = 1'b0;
        o_index = '0;
        w_idx   = 0;
        for (int d = N - 1; d >= 0; d--) begin
            w_idx = (int'(i_start) + N - d) % N;
            if (i_vec[w_idx]) begin
                o_found = 1'b1;
                o_index = W'(w_idx);
            end
        end
    end

endmodule : prio_enc_n

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - fixed/round-robin arbiter holding one grant until release or withdrawal
module priority_arbiter
    import arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_mode,
    input  logic         i_release,
    output logic         o_gnt_valid,
    output logic [W-1:0] o_gnt_id,
    output logic [N-1:0] o_gnt_onehot
);

    localparam logic [W-1:0] START_FIXED = W'(N - 1);
    localparam logic [N-1:0] ONE_N       = {{(N-1){1'b0}}, 1'b1};

    arb_state_t   r_state;
    logic         r_gnt_valid;
    logic [W-1:0] r_gnt_id;
    logic [N-1:0] r_gnt_onehot;
    logic [W-1:0] r_ptr;

    arb_state_t   w_state_nxt;
    logic         w_valid_nxt;
    logic [W-1:0] w_id_nxt;
    logic [N-1:0] w_onehot_nxt;
    logic [W-1:0] w_ptr_nxt;

    logic         w_fix_found;
    logic [W-1:0] w_fix_idx;
    logic         w_rr_found;
    logic [W-1:0] w_rr_idx;
    logic         w_win_found;
    logic [W-1:0] w_win_idx;
    logic [N-1:0] w_win_onehot;
    logic [W-1:0] w_rr_ptr_nxt;
    logic         w_grant_end;

    // Fixed priority: always start the search at the top index
    prio_enc_n #(.N(N), .W(W)) u_enc_fixed (
        .i_vec   (i_req),
        .i_start (START_FIXED),
        .o_found (w_fix_found),
        .o_index (w_fix_idx)
    );

    // Round-robin: start the search at the rotating pointer
    prio_enc_n #(.N(N), .W(W)) u_enc_rr (
        .i_vec   (i_req),
        .i_start (r_ptr),
        .o_found (w_rr_found),
        .o_index (w_rr_idx)
    );

    // Winner of this cycle under the currently presented mode
    always_comb begin
        w_win_found  = (i_mode == MODE_FIXED) ? w_fix_found : w_rr_found;
        w_win_idx    = (i_mode == MODE_FIXED) ? w_fix_idx   : w_rr_idx;
        w_win_onehot = ONE_N << w_win_idx;
        // Pointer moves just below the winner so it becomes lowest priority
        w_rr_ptr_nxt = (w_win_idx == '0) ? START_FIXED : (w_win_idx - W'(1));
        // Release wins over everything; withdrawal of the holder also ends it
        w_grant_end  = i_release || !i_req[r_gnt_id];
    end

    // Next state and registered outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_gnt_valid;
        w_id_nxt     = r_gnt_id;
        w_onehot_nxt = r_gnt_onehot;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            IDLE: begin
                w_valid_nxt  = 1'b0;
                w_id_nxt     = '0;
                w_onehot_nxt = '0;
                if (w_win_found) begin
                    w_state_nxt  = GRANT;
                    w_valid_nxt  = 1'b1;
                    w_id_nxt     = w_win_idx;
                    w_onehot_nxt = w_win_onehot;
                    if (i_mode == MODE_RR) begin
                        w_ptr_nxt = w_rr_ptr_nxt;
                    end
                end
            end
            GRANT: begin
                // Outputs hold; the cycle after the grant ends is always IDLE,
                // so any pending request waits one cycle to be arbitrated
                if (w_grant_end) begin
                    w_state_nxt  = IDLE;
                    w_valid_nxt  = 1'b0;
                    w_id_nxt     = '0;
                    w_onehot_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_valid_nxt  = 1'b0;
                w_id_nxt     = '0;
                w_onehot_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset drops any grant without a clock edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_id     <= '0;
            r_gnt_onehot <= '0;
            r_ptr        <= START_FIXED;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_valid  <= w_valid_nxt;
            r_gnt_id     <= w_id_nxt;
            r_gnt_onehot <= w_onehot_nxt;
            r_ptr        <= w_ptr_nxt;
        end
    end

    assign o_gnt_valid  = r_gnt_valid;
    assign o_gnt_id     = r_gnt_id;
    assign o_gnt_onehot = r_gnt_onehot;

endmodule : priority_arbiter

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - self-checking bench for priority_arbiter
module tb_priority_arbiter;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic         rel;
    logic         gnt_valid;
    logic [W-1:0] gnt_id;
    logic [N-1:0] gnt_onehot;

    int total;
    int bad;

    // Reference state: holder index or -1 when nobody is granted
    int m_holder;
    int m_ptr;

    typedef struct {
        logic [N-1:0] req;
        logic         mode;
        logic         rel;
        logic         exp_valid;
        int           exp_id;
    } vec_t;

    priority_arbiter #(.N(N), .W(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_mode       (mode),
        .i_release    (rel),
        .o_gnt_valid  (gnt_valid),
        .o_gnt_id     (gnt_id),
        .o_gnt_onehot (gnt_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input int eid);
        logic [N-1:0] eoh;
        eoh = ev ? (N'(1) << eid) : '0;
        check({name, ".valid"}, 64'(gnt_valid), 64'(ev));
        check({name, ".id"}, 64'(gnt_id), ev ? 64'(eid) : 64'd0);
        check({name, ".onehot"}, 64'(gnt_onehot), 64'(eoh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        mode  = 1'b0;
        rel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_holder = -1;
        m_ptr    = N - 1;
    endtask

    // Reference: one clock edge of the arbiter's behaviour
    task automatic model_edge(input logic [N-1:0] r, input logic md, input logic rl);
        int start;
        int idx;
        if (m_holder >= 0) begin
            if (rl || !r[m_holder]) m_holder = -1;
        end else if (r != 0) begin
            start = md ? m_ptr : N - 1;
            for (int d = 0; d < N; d++) begin
                idx = (start - d + N) % N;
                if (r[idx]) begin
                    m_holder = idx;
                    break;
                end
            end
            if (md) m_ptr = (m_holder + N - 1) % N;
        end
    endtask

    initial begin
        vec_t vecs[15];
        total = 0;
        bad   = 0;
        m_holder = -1;
        m_ptr    = N - 1;

        vecs[0]  = '{8'b0010_0110, 1'b0, 1'b0, 1'b1, 5};
        vecs[1]  = '{8'b0010_0110, 1'b0, 1'b0, 1'b1, 5};
        vecs[2]  = '{8'hFF,        1'b0, 1'b1, 1'b0, 0};
        vecs[3]  = '{8'hFF,        1'b0, 1'b0, 1'b1, 7};
        vecs[4]  = '{8'h7F,        1'b0, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h7F,        1'b0, 1'b0, 1'b1, 6};
        vecs[6]  = '{8'h7F,        1'b1, 1'b0, 1'b1, 6};
        vecs[7]  = '{8'h00,        1'b1, 1'b0, 1'b0, 0};
        vecs[8]  = '{8'h00,        1'b1, 1'b1, 1'b0, 0};
        vecs[9]  = '{8'h0C,        1'b1, 1'b0, 1'b1, 3};
        vecs[10] = '{8'h0C,        1'b1, 1'b1, 1'b0, 0};
        vecs[11] = '{8'h0C,        1'b1, 1'b0, 1'b1, 2};
        vecs[12] = '{8'h0C,        1'b1, 1'b1, 1'b0, 0};
        vecs[13] = '{8'h0C,        1'b1, 1'b0, 1'b1, 3};
        vecs[14] = '{8'h0C,        1'b1, 1'b1, 1'b0, 0};

        // Reset state
        rst_n = 1'b0;
        req   = '0;
        mode  = 1'b0;
        rel   = 1'b0;
        #3;
        check_out("reset", 1'b0, 0);
        do_reset();
        check_out("reset_held", 1'b0, 0);

        // Table-driven sequence from reset
        for (int i = 0; i < 15; i++) begin
            req  = vecs[i].req;
            mode = vecs[i].mode;
            rel  = vecs[i].rel;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id);
        end

        // Round-robin rotation with release on each grant
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            rel = 1'b0;
            tick();
            check_out($sformatf("rr_grant%0d", k), 1'b1, (N - 1 - k + N) % N);
            rel = 1'b1;
            tick();
            check_out($sformatf("rr_gap%0d", k), 1'b0, 0);
        end
        rel = 1'b0;

        // Withdrawal of the holder
        do_reset();
        req = 8'h08;
        tick();
        check_out("wd_grant3", 1'b1, 3);
        req = 8'h01;
        tick();
        check_out("wd_drop", 1'b0, 0);
        tick();
        check_out("wd_grant0", 1'b1, 0);

        // Empty input with stray release pulses
        do_reset();
        for (int k = 0; k < 10; k++) begin
            rel = k[0];
            tick();
            check_out($sformatf("empty%0d", k), 1'b0, 0);
        end
        rel = 1'b0;

        // Asynchronous reset mid-grant restores the pointer
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        tick();
        check_out("ar_grant7", 1'b1, 7);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        check_out("ar_grant6", 1'b1, 6);
        rst_n = 1'b0;
        #1;
        check_out("ar_async_drop", 1'b0, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check_out("ar_after_reset7", 1'b1, 7);

        // Mode switch during grant has no effect on the held grant
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        check_out("ms_grant6", 1'b1, 6);
        mode = 1'b0;
        tick();
        check_out("ms_hold6", 1'b1, 6);
        req = 8'h41;
        rel = 1'b1;
        tick();
        check_out("ms_release", 1'b0, 0);
        rel = 1'b0;
        tick();
        check_out("ms_fixed6", 1'b1, 6);

        // Randomized stimulus against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            case ($urandom_range(0, 3))
                0: req = N'($urandom);
                1: req = N'(1) << $urandom_range(0, N - 1);
                2: req = (m_holder >= 0 && $urandom_range(0, 3) != 0) ? (req | (N'(1) << m_holder)) : N'($urandom);
                default: req = '0;
            endcase
            mode = 1'($urandom_range(0, 1));
            rel  = ($urandom_range(0, 3) == 0);
            model_edge(req, mode, rel);
            tick();
            check_out($sformatf("rand%0d", c), m_holder >= 0, (m_holder >= 0) ? m_holder : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_priority_arbiter

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of requesters, legal range 2..64.
REQ-002 SHALL have derived parameter W, default $clog2(N), meaning grant index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, N, request vector; bit i is requester i.
REQ-006 SHALL have port mode, input, 1; 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 SHALL have port release, input, 1, a pulse from the current grantee that ends its grant.
REQ-008 SHALL have port gnt_valid, output, 1, high while a grant is held.
REQ-009 SHALL have port gnt_id, output, W, binary index of the granted requester.
REQ-010 SHALL have port gnt_onehot, output, N, one-hot copy of gnt_id, qualified by gnt_valid.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and GRANT, all outputs registered.
REQ-012 In IDLE with req nonzero, the block SHALL select a winner, enter GRANT, and assert gnt_valid/gnt_id/gnt_onehot on the next edge; latency from req to grant is 1 cycle.
REQ-013 In IDLE with req all-zero, the block SHALL stay in IDLE with gnt_valid=0, gnt_id=0 and gnt_onehot=0.
REQ-014 Fixed mode SHALL select the highest-index set bit of req.
REQ-015 Round-robin mode SHALL search downward from pointer ptr, wrapping from 0 to N-1, and select the first set bit.
REQ-016 On each grant to index k in round-robin mode, ptr SHALL update to (k-1) mod N; a grant to 0 gives ptr = N-1.
REQ-017 In fixed mode ptr SHALL hold its value.
REQ-018 mode SHALL be sampled only in IDLE at the arbitration edge; a change during GRANT has no effect on the current grant.
REQ-019 In GRANT, gnt_id/gnt_onehot SHALL remain stable, independent of changes on req.
REQ-020 GRANT SHALL end on release=1, or on req[gnt_id]=0 (requester withdrawal), whichever occurs first; the next edge returns to IDLE with all outputs 0.
REQ-021 A new grant SHALL NOT be issued in the cycle following the end of a grant; at least one IDLE cycle separates grants.
REQ-022 release while in IDLE SHALL be ignored.
REQ-023 If release and a new req arrive together in GRANT, release SHALL take effect, and the new req SHALL be arbitrated on the IDLE cycle that follows.
REQ-024 gnt_onehot SHALL always equal (1 << gnt_id) when gnt_valid=1, and 0 otherwise.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, gnt_valid=0, gnt_id=0, gnt_onehot=0, ptr=N-1.
REQ-026 Reset asserted during GRANT SHALL drop the grant immediately, without waiting for a clock edge.
REQ-027 The first arbitration after reset deassertion SHALL occur at the first rising edge with rst_n=1.
REQ-028 After reset, round-robin mode SHALL behave identically to fixed mode for the first grant.

Structure
REQ-029 The state enum (IDLE, GRANT) SHALL reside in shared package arb_pkg.
REQ-030 Mode encodings MODE_FIXED=0 and MODE_RR=1 SHALL reside in arb_pkg.
REQ-031 Winner selection SHALL be a combinational sub-module prio_enc_n (params N, W; inputs vector, start index; outputs found, index), searching downward with wrap.
REQ-032 Fixed mode SHALL use prio_enc_n with start=N-1.

Verification
REQ-033 The bench SHALL cover fixed priority: N=8, mode=0, req=8'b0010_0110 -> next cycle gnt_valid=1, gnt_id=5, gnt_onehot=8'b0010_0000.
REQ-034 The bench SHALL cover round-robin rotation: mode=1, req=8'hFF held, release pulsed on each grant -> gnt_id sequence 7,6,5,...,0,7 with one IDLE cycle between grants.
REQ-035 The bench SHALL cover withdrawal: grant to 3, then req[3] drops -> gnt_valid=0 on the next edge, and with req=8'h01 the next grant is id 0 two cycles later.
REQ-036 The bench SHALL cover empty input: req=0 for 10 cycles -> gnt_valid stays 0, and release pulses are ignored.
REQ-037 The bench SHALL cover async reset: rst_n=0 mid-GRANT -> gnt_valid=0 before the next edge, and ptr=7 (next RR grant with req=8'hFF is id 7).
REQ-038 The bench SHALL cover a mode switch during GRANT: grant to 6 in RR, set mode=0 before release -> no change to the current grant; the next grant with req=8'h41 is id 6.
